// File: rtl/score_keeper.sv
// Game-progress stage: apple counter, IDLE/PLAY/WIN/OVER FSM, speed select
// and the scan clock for the seven-segment display driver.
module score_keeper #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 100,
  parameter int MAX_SCORE = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       eat,
  input  logic       crash,
  output logic [3:0] score,
  output logic       clk_100Hz,
  output logic [1:0] state,
  output logic [1:0] speed_level,
  output logic       score_pulse
);

  localparam int HALF = CLK_HZ / (2 * SCAN_HZ);
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
  localparam logic [3:0] MAX_S = 4'(MAX_SCORE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       score_reg, score_next;
  logic             pulse_reg, pulse_next;
  logic             start_d_reg, eat_d_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             scan_reg;
  logic             start_rise, eat_rise;

  assign start_rise = start & ~start_d_reg;
  assign eat_rise   = eat & ~eat_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      score_reg   <= 4'd0;
      pulse_reg   <= 1'b0;
      start_d_reg <= 1'b0;
      eat_d_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      score_reg   <= score_next;
      pulse_reg   <= pulse_next;
      start_d_reg <= start;
      eat_d_reg   <= eat;
    end
  end

  // Crash wins over a same-cycle eat edge; the winning increment moves to WIN on the same edge.
  always_comb begin
    state_next = state_reg;
    score_next = score_reg;
    pulse_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_rise) begin
          state_next = PLAY;
          score_next = 4'd0;
        end
      end
      PLAY: begin
        if (crash) begin
          state_next = OVER;
        end else if (eat_rise) begin
          score_next = score_reg + 4'd1;
          pulse_next = 1'b1;
          if (score_reg + 4'd1 == MAX_S) state_next = WIN;
        end
      end
      WIN, OVER: begin
        if (start_rise) begin
          state_next = PLAY;
          score_next = 4'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      scan_reg <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg  <= '0;
      scan_reg <= ~scan_reg;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
    end
  end

  assign score       = score_reg;
  assign state       = state_reg;
  assign score_pulse = pulse_reg;
  assign speed_level = score_reg[3:2];
  assign clk_100Hz   = scan_reg;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper at CLK_HZ=1000, SCAN_HZ=100 (HALF=5), MAX_SCORE=13.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       eat = 1'b0;
  logic       crash = 1'b0;
  logic [3:0] score;
  logic       clk_100Hz;
  logic [1:0] state;
  logic [1:0] speed_level;
  logic       score_pulse;

  int checks = 0;
  int failures = 0;

  score_keeper #(
    .CLK_HZ(1000),
    .SCAN_HZ(100),
    .MAX_SCORE(13)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .eat(eat),
    .crash(crash),
    .score(score),
    .clk_100Hz(clk_100Hz),
    .state(state),
    .speed_level(speed_level),
    .score_pulse(score_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; eat = 1'b0; crash = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic eat_edge();
    eat = 1'b1; tick();
    eat = 1'b0; tick();
  endtask

  task automatic test_reset();
    logic exp_scan;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (score !== 4'd0 || state !== 2'd0 || score_pulse !== 1'b0 || clk_100Hz !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: score=%0d state=%0d pulse=%0d scan=%0d expected 0 0 0 0",
               score, state, score_pulse, clk_100Hz);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_scan = ((k / 5) % 2) == 1;
      checks++;
      if (clk_100Hz !== exp_scan) begin
        failures++;
        $display("FAIL divider_cycle%0d: clk_100Hz=%0d expected %0d", k, clk_100Hz, exp_scan);
      end
      checks++;
      if (score !== 4'd0 || state !== 2'd0 || speed_level !== 2'd0) begin
        failures++;
        $display("FAIL idle_hold_cycle%0d: score=%0d state=%0d speed=%0d expected 0 0 0",
                 k, score, state, speed_level);
      end
    end
    $display("test_reset: divider and reset values checked");
  endtask

  task automatic test_single_count();
    int pulses;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (state !== 2'd1 || score !== 4'd0) begin
      failures++;
      $display("FAIL start_latency: state=%0d score=%0d expected 1 0", state, score);
    end
    tick();
    pulses = 0;
    eat = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) begin
        checks++;
        if (score !== 4'd1 || score_pulse !== 1'b1) begin
          failures++;
          $display("FAIL eat_latency: score=%0d pulse=%0d expected 1 1", score, score_pulse);
        end
      end
      if (score_pulse === 1'b1) pulses++;
    end
    checks++;
    if (score !== 4'd1 || pulses != 1) begin
      failures++;
      $display("FAIL eat_held: score=%0d pulses=%0d expected 1 1", score, pulses);
    end
    eat = 1'b0; tick();
    eat = 1'b1; tick();
    checks++;
    if (score !== 4'd2 || score_pulse !== 1'b1) begin
      failures++;
      $display("FAIL eat_rearm: score=%0d pulse=%0d expected 2 1", score, score_pulse);
    end
    eat = 1'b0; tick();
    checks++;
    if (score_pulse !== 1'b0) begin
      failures++;
      $display("FAIL pulse_clear: pulse=%0d expected 0", score_pulse);
    end
    $display("test_single_count: score=%0d", score);
  endtask

  task automatic test_win();
    do_reset();
    do_start();
    for (int k = 1; k <= 12; k++) begin
      eat_edge();
      checks++;
      if (score !== 4'(k) || speed_level !== 2'(k / 4)) begin
        failures++;
        $display("FAIL win_step%0d: score=%0d speed=%0d expected %0d %0d",
                 k, score, speed_level, k, k / 4);
      end
    end
    checks++;
    if (speed_level !== 2'd3 || state !== 2'd1) begin
      failures++;
      $display("FAIL win_pre: speed=%0d state=%0d expected 3 1", speed_level, state);
    end
    eat = 1'b1; tick();
    checks++;
    if (score !== 4'd13 || state !== 2'd2 || score_pulse !== 1'b1) begin
      failures++;
      $display("FAIL win_edge: score=%0d state=%0d pulse=%0d expected 13 2 1",
               score, state, score_pulse);
    end
    eat = 1'b0; tick();
    for (int k = 0; k < 3; k++) begin
      eat = 1'b1; tick();
      checks++;
      if (score !== 4'd13 || state !== 2'd2 || score_pulse !== 1'b0) begin
        failures++;
        $display("FAIL win_frozen%0d: score=%0d state=%0d pulse=%0d expected 13 2 0",
                 k, score, state, score_pulse);
      end
      eat = 1'b0; tick();
    end
    $display("test_win: score=%0d state=%0d", score, state);
  endtask

  task automatic test_crash_priority();
    do_reset();
    do_start();
    repeat (5) eat_edge();
    crash = 1'b1; eat = 1'b1; tick();
    checks++;
    if (state !== 2'd3 || score !== 4'd5 || score_pulse !== 1'b0) begin
      failures++;
      $display("FAIL crash_priority: state=%0d score=%0d pulse=%0d expected 3 5 0",
               state, score, score_pulse);
    end
    crash = 1'b0; eat = 1'b0; tick();
    eat_edge();
    checks++;
    if (state !== 2'd3 || score !== 4'd5) begin
      failures++;
      $display("FAIL over_frozen: state=%0d score=%0d expected 3 5", state, score);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (state !== 2'd1 || score !== 4'd0) begin
      failures++;
      $display("FAIL over_restart: state=%0d score=%0d expected 1 0", state, score);
    end
    tick();
    $display("test_crash_priority: state=%0d score=%0d", state, score);
  endtask

  task automatic test_reset_mid_game();
    do_reset();
    do_start();
    repeat (7) eat_edge();
    checks++;
    if (score !== 4'd7) begin
      failures++;
      $display("FAIL mid_setup: score=%0d expected 7", score);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (score !== 4'd0 || state !== 2'd0 || clk_100Hz !== 1'b0 || score_pulse !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: score=%0d state=%0d scan=%0d pulse=%0d expected 0 0 0 0",
               score, state, clk_100Hz, score_pulse);
    end
    repeat (3) tick();
    rst_n = 1'b1; tick();
    eat_edge();
    checks++;
    if (score !== 4'd0 || state !== 2'd0) begin
      failures++;
      $display("FAIL idle_eat: score=%0d state=%0d expected 0 0", score, state);
    end
    rst_n = 1'b0; eat = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    do_start();
    repeat (3) tick();
    checks++;
    if (score !== 4'd0 || state !== 2'd1) begin
      failures++;
      $display("FAIL eat_through_reset: score=%0d state=%0d expected 0 1", score, state);
    end
    eat = 1'b0; tick();
    eat = 1'b1; tick();
    checks++;
    if (score !== 4'd1) begin
      failures++;
      $display("FAIL eat_after_toggle: score=%0d expected 1", score);
    end
    eat = 1'b0; tick();
    $display("test_reset_mid_game: score=%0d state=%0d", score, state);
  endtask

  task automatic test_start_in_play();
    do_reset();
    do_start();
    repeat (4) eat_edge();
    start = 1'b1; tick();
    checks++;
    if (score !== 4'd4 || state !== 2'd1 || speed_level !== 2'd1) begin
      failures++;
      $display("FAIL start_in_play: score=%0d state=%0d speed=%0d expected 4 1 1",
               score, state, speed_level);
    end
    start = 1'b0; tick();
    $display("test_start_in_play: score=%0d state=%0d", score, state);
  endtask

  initial begin
    test_reset();
    test_single_count();
    test_win();
    test_crash_priority();
    test_reset_mid_game();
    test_start_in_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-progress stage directly upstream of the seven-segment display driver. Counts apples eaten, runs the IDLE/PLAY/WIN/OVER game FSM, and produces the 4-bit `score` the display consumes. Also generates the `clk_100Hz` scan clock the display uses for digit multiplexing, so a single instance feeds both display inputs.

## Interface

**Parameters**

- `CLK_HZ`, default 100_000_000: frequency of `clk`.
- `SCAN_HZ`, default 100: frequency of the `clk_100Hz` output.
- `MAX_SCORE`, default 13: winning score. Must be in the range 1..13, the display's supported range.

**Ports** (clock and reset first)

- `clk` input, 1: system clock. Single clock domain; all logic on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: start/restart request from the game-control button, already debounced and synchronous to `clk`.
- `eat` input, 1: level from the snake logic, high while the head overlaps an apple. May stay high for many cycles.
- `crash` input, 1: level from the snake logic, high when the head hits a wall or its body.
- `score` output, 4: current score, 0..MAX_SCORE. Feeds the display.
- `clk_100Hz` output, 1: 50% duty square wave at SCAN_HZ. Feeds the display scan.
- `state` output, 2: game state. IDLE=0, PLAY=1, WIN=2, OVER=3.
- `speed_level` output, 2: snake speed select for the movement timer.
- `score_pulse` output, 1: one-cycle strobe on every score increment.

## Operation

- **Edge detection.** Registers `start_d` and `eat_d` reset to 0.
  - `start_rise = start & ~start_d`.
  - `eat_rise = eat & ~eat_d`.
  - `crash` is level-sensitive and needs no edge detection.
- **FSM.**
  - **IDLE:** on `start_rise`, go to PLAY and clear `score` to 0. Ignore `eat` and `crash`.
  - **PLAY:**
    - `crash`=1 → OVER. `crash` has priority over a same-cycle `eat_rise`: no increment, no pulse.
    - Else on `eat_rise`: `score <= score+1` and `score_pulse` = 1 for one cycle.
    - If `score+1 == MAX_SCORE`, go to WIN on the same edge.
    - `start_rise` is ignored in PLAY.
  - **WIN / OVER:** `score` is frozen; `eat` and `crash` are ignored. On `start_rise`, go to PLAY with `score` = 0.
  - Illegal encodings cannot occur with 2-bit full coverage; the default branch goes to IDLE.
- **Score width.** `score` never exceeds MAX_SCORE. The increment is only reachable while `score < MAX_SCORE`, so there is no wrap.
- **speed_level.** Combinational from the `score` register: `score[3:2]`. Scores 0–3 → 0, 4–7 → 1, 8–11 → 2, 12–13 → 3. No extra latency.
- **Scan divider.**
  - `HALF = CLK_HZ/(2*SCAN_HZ)`, with counter width `$clog2(HALF)`.
  - The counter runs 0..HALF-1. At HALF-1 it returns to 0 and `clk_100Hz` toggles.
  - The divider runs freely in every FSM state and is unaffected by `start`.

## Timing

- **Reset values** while `rst_n`=0, applied immediately:
  - `state` = IDLE, `score` = 0, `score_pulse` = 0, `clk_100Hz` = 0.
  - Divider counter = 0; `start_d` = `eat_d` = 0.
  - `speed_level` = 0, since it follows `score`.
- **Eat latency.** `eat` is sampled high at edge N with `eat_d`=0, so `score` and `score_pulse` update on edge N (visible after N). `score_pulse` clears at N+1. `eat` held high yields exactly one increment.
- **Re-arm.** A second increment requires `eat` to go low for at least one sampled cycle and then high again.
- **Start latency.** `start` rises at edge N → `state` = PLAY and `score` = 0 after edge N.
- **Crash latency.** `crash` = 1 at edge N in PLAY → `state` = OVER after edge N.
- **Reaching MAX_SCORE.** The final increment, the WIN transition and `score_pulse` all occur on the same edge.
- **`clk_100Hz` period.** Exactly 2·HALF `clk` cycles; the first rising edge of `clk_100Hz` comes HALF cycles after reset release.
- **Reset mid-game.** Asserting `rst_n`=0 at any point aborts the game and restores all reset values asynchronously. Operation after release proceeds from IDLE.
- **`eat` high through reset release.** If `eat` is high when reset releases, the edge is seen in IDLE and discarded. No increment occurs after a later `start` until `eat` toggles.

## Test plan

1. **Reset and divider.** Use CLK_HZ=1000, SCAN_HZ=100 (HALF=5). Release reset → `clk_100Hz` rises at cycle 5 and falls at cycle 10, with period 10. Confirm `score`=0, `state`=0 and `speed_level`=0 throughout.
2. **Single count per eat.** Start the game, then hold `eat` high for 20 cycles → `score`=1 and exactly one `score_pulse`. Drop `eat` for 1 cycle, then raise it → `score`=2.
3. **Win.** With MAX_SCORE=13, apply 13 eat edges. After the 12th edge, check `speed_level`=3. On the 13th edge, check `score`=13, `state`=2 (WIN) and a pulse on that edge. Further eat edges leave `score`=13.
4. **Crash priority.** In PLAY with `score`=5, raise `crash` and `eat` in the same cycle → `state`=3 (OVER) and `score` stays 5 with no pulse. Then `start_rise` → `state`=1 and `score`=0.
5. **Reset mid-game.** At `score`=7 in PLAY, pulse `rst_n` low for 3 cycles → `score`=0, `state`=0 and `clk_100Hz`=0 immediately. An `eat` edge while in IDLE leaves `score`=0.
6. **Start ignored in PLAY.** At `score`=4 in PLAY, apply a `start` edge → `score` stays 4 and `state` stays 1.
